// File: rtl/mux_scan_pkg.sv
// Shared types and helpers for the mux_scan_n block.
//   state_t      : FSM state encoding (MANUAL, SCAN, HOLD)
//   DEF_*        : default parameter values for WIDTH, CHANNELS, DWELL
//   width_of(n)  : bits needed to index n items, never less than 1
package mux_scan_pkg;

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    SCAN   = 2'd1,
    HOLD   = 2'd2
  } state_t;

  localparam int DEF_WIDTH    = 2;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_DWELL    = 50_000_000;

  // A count range of 1 still needs a one-bit register.
  function automatic int width_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_n_if.sv
// Signal bundle between a channel source/sink and mux_scan_n.
//   master : drives data_in, sel_in, mode, hold; observes the outputs
//   slave  : the multiplexer itself
//   state  : FSM state, exported for observation only
// Handshake: none. Every clock edge is a transfer. Inputs are sampled on
// each rising edge and the outputs are registered and valid every cycle
// after reset.
interface mux_scan_n_if
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int SELW = width_of(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SELW-1:0]           sel_in;
  logic                      mode;
  logic                      hold;
  logic [WIDTH-1:0]          data_out;
  logic [SELW-1:0]           sel_out;
  logic                      strobe;
  logic                      sel_err;
  state_t                    state;

  modport master (
    output data_in, sel_in, mode, hold,
    input  data_out, sel_out, strobe, sel_err, state
  );

  modport slave (
    input  data_in, sel_in, mode, hold,
    output data_out, sel_out, strobe, sel_err, state
  );

endinterface

// File: rtl/mux_scan_n_dwell_counter.sv
// Dwell counter for the auto-scan sequencer.
//   clk, rst : clock, synchronous active-high reset
//   en       : advance one count; wraps DWELL-1 -> 0
//   clr      : force count to 0 (takes priority over en)
//   tc       : high while the count equals DWELL-1
// With en and clr both low the count is frozen.
module dwell_counter
  import mux_scan_pkg::*;
#(
  parameter int DWELL = DEF_DWELL
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int            CW   = width_of(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] count;

  assign tc = (count == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with manual and auto-scan select.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mux_scan_n_if slave modport
//     data_in  channel k at [k*WIDTH +: WIDTH]   sel_in  manual select
//     mode     0 manual / 1 scan                 hold    freeze selection
//     data_out registered channel data           sel_out current channel
//     strobe   one cycle after sel_out changes   sel_err bad manual select
//     state    FSM state for observation
// Every action on an edge is decided by the state being entered, so hold
// and mode changes override a scan step that would otherwise happen.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int DWELL    = DEF_DWELL
) (
  input  logic        clk,
  input  logic        rst,
  mux_scan_n_if.slave bus
);

  localparam int              SELW    = width_of(CHANNELS);
  localparam logic [SELW:0]   NUM_CH  = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CH = SELW'(CHANNELS - 1);

  state_t            state_q, state_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic [WIDTH-1:0]  data_q;
  logic              strobe_q, err_q;
  logic              sel_in_ok, cnt_en, cnt_clr, tc;

  assign sel_in_ok = ({1'b0, bus.sel_in} < NUM_CH);

  always_comb begin
    state_d = MANUAL;
    if (bus.hold) begin
      state_d = HOLD;
    end else if (bus.mode) begin
      state_d = SCAN;
    end
  end

  // The edge that enters SCAN from MANUAL does not count, so the first
  // channel gets a full dwell. Leaving HOLD counts on from the frozen value.
  always_comb begin
    cnt_en  = (state_d == SCAN) && (state_q != MANUAL);
    cnt_clr = (state_d == MANUAL);
    sel_d   = sel_q;
    case (state_d)
      MANUAL: if (sel_in_ok) sel_d = bus.sel_in;
      SCAN:   if (cnt_en && tc) sel_d = (sel_q == LAST_CH) ? '0 : sel_q + 1'b1;
      default: ;
    endcase
  end

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk (clk),
    .rst (rst),
    .en  (cnt_en),
    .clr (cnt_clr),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= MANUAL;
      sel_q    <= '0;
      data_q   <= '0;
      strobe_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      data_q   <= bus.data_in[sel_d*WIDTH +: WIDTH];
      strobe_q <= (sel_d != sel_q);
      err_q    <= (state_d == MANUAL) && !sel_in_ok;
    end
  end

  assign bus.data_out = data_q;
  assign bus.sel_out  = sel_q;
  assign bus.strobe   = strobe_q;
  assign bus.sel_err  = err_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: a 4-channel and a 3-channel instance (WIDTH=2,
// DWELL=3) share one stimulus stream. Each driven cycle pushes the expected
// post-edge outputs of one chosen instance; a monitor pops and compares.
module tb_mux_scan_n;
  import mux_scan_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux_scan_n_if #(.WIDTH(2), .CHANNELS(4)) bus4 ();
  mux_scan_n_if #(.WIDTH(2), .CHANNELS(3)) bus3 ();

  mux_scan_n #(.WIDTH(2), .CHANNELS(4), .DWELL(3)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  mux_scan_n #(.WIDTH(2), .CHANNELS(3), .DWELL(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Entry layout: {which_dut, data[1:0], sel[1:0], strobe, sel_err}
  logic [6:0] exp_q[$];
  string      name_q[$];
  int         checks = 0;
  int         passed = 0;

  logic [6:0] mon_e;
  logic [5:0] mon_a;
  string      mon_nm;

  localparam logic [7:0] DA = 8'hE4; // ch0..3 = 0,1,2,3
  localparam logic [7:0] DB = 8'h1B; // ch0..3 = 3,2,1,0

  // Drive one cycle of inputs at the falling edge and queue what the chosen
  // instance must show after the next rising edge.
  task automatic cyc(input logic r, input logic [7:0] d, input logic [1:0] s,
                     input logic m, input logic h, input logic w,
                     input logic [1:0] ed, input logic [1:0] es,
                     input logic est, input logic eer, input string nm);
    @(negedge clk);
    rst          = r;
    bus4.data_in = d;
    bus4.sel_in  = s;
    bus4.mode    = m;
    bus4.hold    = h;
    bus3.data_in = d[5:0];
    bus3.sel_in  = s;
    bus3.mode    = m;
    bus3.hold    = h;
    exp_q.push_back({w, ed, es, est, eer});
    name_q.push_back(nm);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e  = exp_q.pop_front();
      mon_nm = name_q.pop_front();
      mon_a  = mon_e[6] ? {bus3.data_out, bus3.sel_out, bus3.strobe, bus3.sel_err}
                        : {bus4.data_out, bus4.sel_out, bus4.strobe, bus4.sel_err};
      checks++;
      if (mon_a !== mon_e[5:0]) begin
        $display("FAIL %s: got data=%b sel=%0d strobe=%b err=%b, expected data=%b sel=%0d strobe=%b err=%b",
                 mon_nm, mon_a[5:4], mon_a[3:2], mon_a[1], mon_a[0],
                 mon_e[5:4], mon_e[3:2], mon_e[1], mon_e[0]);
      end else begin
        passed++;
      end
    end
  end

  initial begin
    logic [1:0] es;
    bus4.data_in = '0; bus4.sel_in = '0; bus4.mode = 1'b0; bus4.hold = 1'b0;
    bus3.data_in = '0; bus3.sel_in = '0; bus3.mode = 1'b0; bus3.hold = 1'b0;

    // Reset, then release into manual select of channel 2
    cyc(1, DA, 2, 0, 0, 0, 2'b00, 0, 0, 0, "reset");
    cyc(0, DA, 2, 0, 0, 0, 2'b10, 2, 1, 0, "rst_release");
    cyc(0, DA, 2, 0, 0, 0, 2'b10, 2, 0, 0, "strobe_once");
    cyc(0, DB, 2, 0, 0, 0, 2'b01, 2, 0, 0, "manual_data");
    cyc(0, DB, 0, 0, 0, 0, 2'b11, 0, 1, 0, "manual_sel");

    // Scan from channel 0: three cycles per channel, wrap 3 -> 0
    for (int k = 0; k < 20; k++) begin
      es = 2'((k / 3) % 4);
      cyc(0, DA, 0, 1, 0, 0, es, es, (k % 3 == 0) && (k != 0), 0, "scan");
    end

    // Hold at count 1 of channel 2; data keeps following channel 2
    for (int k = 0; k < 10; k++) begin
      if (k < 5) cyc(0, DA, 0, 1, 1, 0, 2'b10, 2, 0, 0, "hold");
      else       cyc(0, DB, 0, 1, 1, 0, 2'b01, 2, 0, 0, "hold_data");
    end
    cyc(0, DA, 0, 1, 0, 0, 2'b10, 2, 0, 0, "hold_release");
    cyc(0, DA, 0, 1, 0, 0, 2'b11, 3, 1, 0, "hold_resume");

    // Run on to the terminal cycle of channel 1
    for (int k = 0; k < 8; k++) begin
      es = (k < 2) ? 2'd3 : (k < 5) ? 2'd0 : 2'd1;
      cyc(0, DA, 0, 1, 0, 0, es, es, (k == 2) || (k == 5), 0, "scan2");
    end

    // Leaving scan on the terminal count: no step
    cyc(0, DA, 1, 0, 0, 0, 2'b01, 1, 0, 0, "mode_wins");
    cyc(0, DA, 3, 0, 0, 0, 2'b11, 3, 1, 0, "manual_after");

    // Reset in the middle of a scan dwell on channel 3
    cyc(0, DA, 3, 1, 0, 0, 2'b11, 3, 0, 0, "scan_entry");
    cyc(0, DA, 3, 1, 0, 0, 2'b11, 3, 0, 0, "scan_count");
    cyc(1, DA, 3, 1, 0, 0, 2'b00, 0, 0, 0, "rst_mid");
    cyc(0, DA, 3, 1, 0, 0, 2'b00, 0, 0, 0, "resume0");
    cyc(0, DA, 3, 1, 0, 0, 2'b00, 0, 0, 0, "resume1");
    cyc(0, DA, 3, 1, 0, 0, 2'b00, 0, 0, 0, "resume2");
    cyc(0, DA, 3, 1, 0, 0, 2'b01, 1, 1, 0, "resume_step");

    // Three-channel instance: out-of-range manual select
    cyc(1, DA, 0, 0, 0, 1, 2'b00, 0, 0, 0, "rst3");
    cyc(0, DA, 3, 0, 0, 1, 2'b00, 0, 0, 1, "sel_err_keep0");
    cyc(0, DA, 2, 0, 0, 1, 2'b10, 2, 1, 0, "manual3");
    cyc(0, DA, 3, 0, 0, 1, 2'b10, 2, 0, 1, "sel_err_set");
    cyc(0, DB, 3, 0, 0, 1, 2'b01, 2, 0, 1, "sel_err_data");
    cyc(0, DA, 1, 0, 0, 1, 2'b01, 1, 1, 0, "sel_err_clr");

    // Three-channel scan from channel 1, wrapping 2 -> 0
    for (int k = 0; k < 7; k++) begin
      es = (k < 3) ? 2'd1 : (k < 6) ? 2'd2 : 2'd0;
      cyc(0, DA, 1, 1, 0, 1, es, es, (k == 3) || (k == 6), 0, "scan3");
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mux_scan_n.md
# mux_scan_n

Parametrised, registered N-channel, W-bit multiplexer with manual and auto-scan select modes.
- Manual mode: the output channel follows an external select.
- Scan mode: an internal sequencer steps through channels, holding each for a programmable dwell time and pulsing a strobe on every channel change.
- Sits between switch/data sources and display or downstream logic; generalises the fixed 2-bit 4:1 board multiplexer.

## Interface
Parameters:
- WIDTH, 2, bits per channel (≥1)
- CHANNELS, 4, number of input channels (≥2, need not be a power of 2)
- DWELL, 50_000_000, clock cycles each channel is held in scan mode (≥1)
- SELW, derived = clog2(CHANNELS), select width; not overridable

Ports:
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- data_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- sel_in  in  SELW  manual channel select
- mode  in  1  0 = manual, 1 = auto-scan
- hold  in  1  freezes channel selection (both modes)
- data_out  out  WIDTH  registered selected channel data
- sel_out  out  SELW  channel currently driving data_out
- strobe  out  1  one-cycle pulse when sel_out changes
- sel_err  out  1  registered; high while manual sel_in ≥ CHANNELS

## Operation
States:
- MANUAL (reset state)
- SCAN
- HOLD

Transitions, evaluated each clock:
- Any state → HOLD when hold=1; HOLD → MANUAL or SCAN, per mode, when hold=0.
- MANUAL → SCAN when mode=1; SCAN → MANUAL when mode=0.

MANUAL:
- sel_out ← sel_in each cycle.
- If sel_in ≥ CHANNELS: sel_out keeps its previous value and sel_err=1.
- Dwell counter held at 0.

SCAN:
- Dwell counter counts 0..DWELL-1.
- At DWELL-1: counter → 0 and sel_out → sel_out+1, wrapping CHANNELS-1 → 0.
- Entry from MANUAL starts at the current sel_out with counter 0.

HOLD:
- sel_out and counter frozen.
- data_out keeps tracking data_in of the frozen channel.
- Leaving HOLD resumes counting from the frozen count value; no restart.

Common to all states:
- data_out ← data_in[sel_next], where sel_next is the value sel_out takes on this edge.
- strobe=1 for exactly the cycle after any edge where sel_out changed value. Writing the same value does not strobe.
- Simultaneous mode change and dwell terminal count: the mode change wins. No scan step is taken when leaving SCAN.
- rst has priority over everything, including mid-dwell and during HOLD.

## Timing
- Reset values: data_out=0, sel_out=0, strobe=0, sel_err=0, counter=0, state=MANUAL.
- Manual latency: sel_in/data_in change at edge n → sel_out/data_out valid after edge n+1 (1 cycle).
- Scan period: exactly DWELL cycles per channel. Full rotation = CHANNELS*DWELL cycles.
- DWELL=1: sel_out advances every cycle and strobe stays high continuously.
- No combinational path from inputs to outputs.
- Counter width: clog2(DWELL); the counter never exceeds DWELL-1.

## Structure
- Package mux_scan_pkg:
  - state typedef {MANUAL, SCAN, HOLD}
  - clog2-based width helper
  - default parameter constants
- Sub-module dwell_counter:
  - parameter DWELL
  - inputs clk, rst, en, clr
  - output tc, asserted at count DWELL-1
- Top level holds the FSM, select register and output data register.
- Channel slice is an indexed part-select; no instance per channel.

## Test plan
Bench uses WIDTH=2, CHANNELS=4, DWELL=3 unless stated.
- Reset with data_in=8'hE4, sel_in=2 → after the rst edge data_out=0, sel_out=0, strobe=0. One edge after rst falls: sel_out=2, data_out=2'b10, strobe=1 for one cycle.
- mode=1 from sel_out=0 → sel_out sequence 0,0,0,1,1,1,2,2,2,3,3,3,0. Strobe pulses once per change, including the 3→0 wrap.
- SCAN, hold=1 at count 1 of channel 2 for 10 cycles → sel_out stays 2, no strobe. After release, channel 3 appears 2 cycles later.
- CHANNELS=3 manual, sel_in=3 → sel_err=1 and sel_out keeps its last value. sel_in=1 → sel_err=0, sel_out=1 next cycle.
- mode=0 asserted on the dwell terminal cycle at sel_out=1 → no advance; sel_out follows sel_in on the following edge.
- rst pulse mid-scan at channel 3 → all outputs return to reset values on that edge; scan resumes from channel 0 with counter 0.
